// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined RV32I core. It owns the program
// counter, drives the byte address of a combinational-read instruction
// memory, and captures the returned word into the IF/ID pipeline register
// that feeds decode.
//
// Next-PC priority per cycle:
//   reset > redirect > halt-on-zero (optional) > stall > sequential +4
//
// Optional feature (compile-time macro FETCH_HALT_ON_ZERO_EN):
//   When defined, fetching an all-zero word (unprogrammed memory) parks the
//   stage in HALT. The PC stays on the zero word and decode sees bubbles
//   until a redirect or reset. When undefined, a zero word is delivered as an
//   ordinary instruction and halted_o is tied low.
//
// Ports:
//   clk            in   core clock, rising edge
//   arstn          in   synchronous active-low reset
//   stall_i        in   hazard stall from decode: hold PC and IF/ID
//   redirect_i     in   taken branch/jump or flush request
//   redirect_pc_i  in   redirect target byte address (low two bits ignored)
//   imem_addr_o    out  byte address to instruction memory (pc truncated)
//   imem_instr_i   in   instruction word for the current pc
//   id_valid_o     out  IF/ID holds a real instruction
//   id_instr_o     out  IF/ID instruction (NOP_INSTR when not valid)
//   id_pc_o        out  pc of id_instr_o
//   id_pc_plus4_o  out  id_pc_o + 4, link value for jal/jalr
//   halted_o       out  fetch parked on a zero word (optional feature only)
//   fetch_cnt_o    out  count of valid instructions delivered to decode
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned       PC_W      = 32,
    parameter int unsigned       IMEM_AW   = 8,
    parameter logic [PC_W-1:0]   RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [PC_W-1:0]     redirect_pc_i,
    output logic [IMEM_AW-1:0]  imem_addr_o,
    input  logic [31:0]         imem_instr_i,
    output logic                id_valid_o,
    output logic [31:0]         id_instr_o,
    output logic [PC_W-1:0]     id_pc_o,
    output logic [PC_W-1:0]     id_pc_plus4_o,
    output logic                halted_o,
    output logic [31:0]         fetch_cnt_o
);

    // ------------------------------------------------------------------
    // Stage 0: program counter
    // ------------------------------------------------------------------
    logic [PC_W-1:0] pc_p0;
    logic [PC_W-1:0] pc_n;
    logic [PC_W-1:0] pc_plus4_p0;
    logic [PC_W-1:0] redirect_tgt;

    // IF/ID register (stage 1)
    logic            vld_p1;
    logic [31:0]     instr_p1;
    logic [PC_W-1:0] pc_p1;
    logic [PC_W-1:0] pc4_p1;

    logic [31:0]     cnt_q;

    // Per-cycle actions decided by the control logic below
    logic            load_instr;
    logic            load_bubble;

    // Redirect targets are forced to word alignment; the dropped low bits
    // are deliberately unused.
    logic [1:0]      unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc_i[1:0];

    assign redirect_tgt = {redirect_pc_i[PC_W-1:2], 2'b00};
    assign pc_plus4_p0  = pc_p0 + PC_W'(4);
    assign imem_addr_o  = pc_p0[IMEM_AW-1:0];

`ifdef FETCH_HALT_ON_ZERO_EN
    // ------------------------------------------------------------------
    // RUN/HALT controller
    // ------------------------------------------------------------------
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_n;

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        pc_n        = pc_p0;
        load_instr  = 1'b0;
        load_bubble = 1'b0;
        if (redirect_i) begin
            pc_n        = redirect_tgt;
            load_bubble = 1'b1;
            state_n     = RUN;
        end else if (state_q == HALT) begin
            // Parked: PC holds on the zero word and IF/ID already holds a
            // bubble, so nothing changes until redirect or reset.
            pc_n = pc_p0;
        end else if (imem_instr_i == 32'h0) begin
            // Zero word outranks stall: stop on it, hand decode a bubble.
            load_bubble = 1'b1;
            state_n     = HALT;
        end else if (!stall_i) begin
            pc_n       = pc_plus4_p0;
            load_instr = 1'b1;
        end
    end

    assign halted_o = (state_q == HALT);
`else
    // ------------------------------------------------------------------
    // Next-PC selection (no halt state in this build)
    // ------------------------------------------------------------------
    always_comb begin
        pc_n        = pc_p0;
        load_instr  = 1'b0;
        load_bubble = 1'b0;
        if (redirect_i) begin
            pc_n        = redirect_tgt;
            load_bubble = 1'b1;
        end else if (!stall_i) begin
            pc_n       = pc_plus4_p0;
            load_instr = 1'b1;
        end
    end

    assign halted_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!arstn) begin
            pc_p0 <= RESET_PC;
        end else begin
            pc_p0 <= pc_n;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: IF/ID register and delivered-instruction counter
    // ------------------------------------------------------------------
    // A bubble only rewrites valid and instr; the pc fields keep their last
    // value since decode ignores them while valid is low.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            vld_p1   <= 1'b0;
            instr_p1 <= NOP_INSTR;
            pc_p1    <= '0;
            pc4_p1   <= '0;
            cnt_q    <= '0;
        end else if (load_instr) begin
            vld_p1   <= 1'b1;
            instr_p1 <= imem_instr_i;
            pc_p1    <= pc_p0;
            pc4_p1   <= pc_plus4_p0;
            cnt_q    <= cnt_q + 32'd1;
        end else if (load_bubble) begin
            vld_p1   <= 1'b0;
            instr_p1 <= NOP_INSTR;
        end
    end

    assign id_valid_o    = vld_p1;
    assign id_instr_o    = instr_p1;
    assign id_pc_o       = pc_p1;
    assign id_pc_plus4_o = pc4_p1;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arstn;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic        halted_o;
    logic [31:0] fetch_cnt_o;

    // 256-byte memory = 64 words, combinational read
    logic [31:0] mem [64];

    int total = 0;
    int bad   = 0;

    // Reference state, expressed as what the spec says is visible
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [31:0] m_idpc4;
    logic [31:0] m_cnt;
    logic        m_halt;

    fetch_stage dut (
        .clk           (clk),
        .arstn         (arstn),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_pc_plus4_o (id_pc_plus4_o),
        .halted_o      (halted_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    assign imem_instr_i = mem[imem_addr_o[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr",   {24'h0, imem_addr_o}, {24'h0, m_pc[7:0]});
        chk("id_valid",    {31'h0, id_valid_o},  {31'h0, m_valid});
        chk("id_instr",    id_instr_o,           m_instr);
        chk("id_pc",       id_pc_o,              m_idpc);
        chk("id_pc_plus4", id_pc_plus4_o,        m_idpc4);
        chk("fetch_cnt",   fetch_cnt_o,          m_cnt);
        chk("halted",      {31'h0, halted_o},    {31'h0, m_halt});
    endtask

    // One clock: advance the model from the inputs present before the edge,
    // then compare after the edge has settled.
    task automatic cyc();
        logic [31:0] w;
        w = mem[m_pc[7:2]];
        if (!arstn) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP;
            m_idpc = 32'h0; m_idpc4 = 32'h0; m_cnt = 32'h0; m_halt = 1'b0;
        end else if (redirect_i) begin
            m_pc = redirect_pc_i & ~32'h3;
            m_valid = 1'b0; m_instr = NOP; m_halt = 1'b0;
        end else if (m_halt) begin
            // parked
        end else if (HALT_EN && w == 32'h0) begin
            m_valid = 1'b0; m_instr = NOP; m_halt = 1'b1;
        end else if (!stall_i) begin
            m_valid = 1'b1; m_instr = w;
            m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        mem[0] = 32'h0020_0613;
        mem[1] = 32'h0030_0693;
        mem[2] = 32'h00e0_0913;
    endtask

    initial begin
        fill_mem();
        arstn = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        m_pc = 32'hx; m_valid = 1'bx; m_instr = 32'hx; m_idpc = 32'hx;
        m_idpc4 = 32'hx; m_cnt = 32'hx; m_halt = 1'bx;

        // Reset
        #2;
        cyc();
        cyc();
        chk("rst_instr_nop", id_instr_o, NOP);

        // Free run from reset
        arstn = 1'b1;
        cyc();
        chk("first_instr", id_instr_o, 32'h0020_0613);
        chk("first_pc4",   id_pc_plus4_o, 32'h4);
        cyc();
        chk("second_pc", id_pc_o, 32'h4);
        cyc();
        chk("third_pc", id_pc_o, 32'h8);
        chk("cnt_after3", fetch_cnt_o, 32'd3);

        // Stall three cycles while id_pc=8
        stall_i = 1'b1;
        repeat (3) cyc();
        chk("stall_addr", {24'h0, imem_addr_o}, 32'h0C);
        chk("stall_pc",   id_pc_o, 32'h8);
        stall_i = 1'b0;
        cyc();
        chk("resume_pc", id_pc_o, 32'h0C);

        // Run to pc 0x40 then redirect to 0x1E
        for (int k = 0; k < 40 && m_pc != 32'h40; k++) cyc();
        chk("reach_40", {24'h0, imem_addr_o}, 32'h40);
        redirect_i = 1'b1; redirect_pc_i = 32'h1E;
        cyc();
        chk("redir_addr",  {24'h0, imem_addr_o}, 32'h1C);
        chk("redir_valid", {31'h0, id_valid_o}, 32'h0);
        chk("redir_instr", id_instr_o, NOP);
        redirect_i = 1'b0;
        cyc();
        chk("redir_tgt_pc", id_pc_o, 32'h1C);

        // Redirect together with stall: redirect wins
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h80;
        cyc();
        chk("redir_stall_addr", {24'h0, imem_addr_o}, 32'h80);
        redirect_i = 1'b0; stall_i = 1'b0;
        cyc();

        // Back-to-back redirects
        redirect_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            redirect_pc_i = 32'h10 * (k + 1);
            cyc();
        end
        redirect_i = 1'b0;
        cyc();

        // Zero word at 0x44
        mem[17] = 32'h0;
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        cyc();
        redirect_i = 1'b0;
        cyc();
        stall_i = 1'b1;
        repeat (3) cyc();
        stall_i = 1'b0;
        repeat (2) cyc();
        if (HALT_EN) begin
            chk("halt_flag", {31'h0, halted_o}, 32'h1);
            chk("halt_addr", {24'h0, imem_addr_o}, 32'h44);
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h0;
        cyc();
        redirect_i = 1'b0;
        chk("unhalt_flag", {31'h0, halted_o}, 32'h0);
        cyc();
        chk("restart_pc", id_pc_o, 32'h0);
        mem[17] = 32'h0000_0013;

        // PC wrap at 2^32
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        cyc();
        redirect_i = 1'b0;
        repeat (4) cyc();

        // Randomized traffic, with occasional zero words
        for (int i = 0; i < 64; i++) if ($urandom_range(15) == 0) mem[i] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            arstn         = ($urandom_range(99) != 0);
            stall_i       = ($urandom_range(3) == 0);
            redirect_i    = ($urandom_range(9) == 0);
            redirect_pc_i = $urandom;
            cyc();
        end
        stall_i = 1'b0; redirect_i = 1'b0; arstn = 1'b1;

        // Reset mid-stream at pc 0x28 with stall asserted
        fill_mem();
        redirect_i = 1'b1; redirect_pc_i = 32'h0;
        cyc();
        redirect_i = 1'b0;
        for (int k = 0; k < 40 && m_pc != 32'h28; k++) cyc();
        chk("reach_28", {24'h0, imem_addr_o}, 32'h28);
        stall_i = 1'b1; arstn = 1'b0;
        cyc();
        chk("mid_rst_addr", {24'h0, imem_addr_o}, 32'h0);
        chk("mid_rst_cnt",  fetch_cnt_o, 32'h0);
        arstn = 1'b1; stall_i = 1'b0;
        repeat (3) cyc();
        chk("post_rst_pc", id_pc_o, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound in case the clock or sequence stalls
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
